// File: rtl/conv2d_edge_acc_sat.sv
// Accumulates one window of signed tap products, applies a rounded right shift and
// saturates to an 8-bit pixel. Optional macro CONV2D_EDGE_ABS_EN selects |r| instead of a ReLU clamp.
module conv2d_edge_acc_sat #(
  parameter int TAPS   = 9,
  parameter int PROD_W = 17,
  parameter int ACC_W  = 22,
  parameter int SHIFT  = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] s_prod,
  input  logic              s_neg,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_pix,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              err_align
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND      = ACC_W'((2 ** SHIFT) / 2);
  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'(255);

  logic [CNT_W-1:0]        cnt_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] prod_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] res_s;
  logic [7:0]              pix_r;
  logic                    valid_r;
  logic                    err_r;
  logic                    accept_s;
  logic                    last_tap_s;

  // Negative results either clamp to zero or fold to their magnitude before saturation.
  function automatic logic [7:0] sat_pix(input logic signed [ACC_W-1:0] r);
    logic signed [ACC_W-1:0] mag;
    mag = r;
    if (r[ACC_W-1]) begin
`ifdef CONV2D_EDGE_ABS_EN
      mag = -r;
`else
      mag = {ACC_W{1'b0}};
`endif
    end else begin
      mag = r;
    end
    if (mag > PIX_MAX) begin
      return 8'hFF;
    end else begin
      return mag[7:0];
    end
  endfunction

  assign s_ready    = !valid_r | m_ready;
  assign accept_s   = s_valid & s_ready;
  assign last_tap_s = (cnt_r == LAST_CNT);

  assign m_pix      = pix_r;
  assign m_valid    = valid_r;
  assign err_align  = err_r;

  // Running sum including the current tap, and its rounded/shifted result.
  always_comb begin
    prod_s = {{(ACC_W-PROD_W){1'b0}}, s_prod};
    sum_s  = {ACC_W{1'b0}};
    if (s_neg) begin
      sum_s = acc_r - prod_s;
    end else begin
      sum_s = acc_r + prod_s;
    end
    res_s = (sum_s + RND) >>> SHIFT;
  end

  // Window accumulator, tap counter, output register and sticky alignment flag.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      pix_r   <= 8'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (valid_r && m_ready) begin
        valid_r <= 1'b0;
      end
      if (accept_s) begin
        if (last_tap_s) begin
          // A new pixel may load in the same cycle the previous one hands off.
          cnt_r   <= {CNT_W{1'b0}};
          acc_r   <= {ACC_W{1'b0}};
          pix_r   <= sat_pix(res_s);
          valid_r <= 1'b1;
          if (!s_last) begin
            err_r <= 1'b1;
          end
        end else if (s_last) begin
          cnt_r <= {CNT_W{1'b0}};
          acc_r <= {ACC_W{1'b0}};
          err_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
          acc_r <= sum_s;
        end
      end
    end
  end

endmodule
